instr_fetch_unit: RTL and testbench

//  Fetch stage of the CPU. Owns the PC and drives the word address of the

---
 rtl/cpu_pkg.sv | 13 +
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/fetch_queue.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 52 +++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, constants and the fetch entry type
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000000;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h00000000;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
        logic err;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: ROM, redirect and decode handshake bundle of the fetch stage
interface instr_fetch_unit_if #(parameter int ROM_AW = 6);
    import cpu_pkg::*;
    logic [ROM_AW-1:0] rom_addr;
    logic [INSTR_W-1:0] rom_instr;
    logic redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0] if_pc;
    logic if_err;
    logic id_ready;

    modport master (
        output rom_addr, if_valid, if_instr, if_pc, if_err,
        input rom_instr, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input rom_addr, if_valid, if_instr, if_pc, if_err,
        output rom_instr, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry shifting FIFO of fetch entries; head always sits in slot 0
module fetch_queue
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);
    fetch_entry_t slot0_q, slot0_d, slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic [1:0] fill;

    // pop shifts slot 1 forward, then a push lands in the first free slot
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        fill = count_q - {1'b0, pop};
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) slot0_d = slot1_q;
            if (push && fill == 2'd0) slot0_d = push_entry;
            if (push && fill != 2'd0) slot1_d = push_entry;
            count_d = fill + {1'b0, push};
        end
    end

    // queue storage and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head_valid = count_q != 2'd0;
    assign head = slot0_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner feeding a 2-entry fetch queue; optional IFETCH_BOUNDS_EN flags out-of-ROM fetches
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ROM_AW = 6,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic clk,
    input logic rst,
    instr_fetch_unit_if.master bus
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic pop, push;
    logic [1:0] count;
    logic head_valid;
    fetch_entry_t push_entry, head;

    // handshake, fetch entry formation and next PC; redirect beats a push
    always_comb begin
        pop = head_valid & bus.id_ready;
        push = ~bus.redirect_valid & (count < 2'd2 | pop);
        push_entry = '{pc: pc_q, instr: bus.rom_instr, err: 1'b0};
`ifdef IFETCH_BOUNDS_EN
        if (pc_q[PC_W-1:ROM_AW+2] != '0) push_entry = '{pc: pc_q, instr: NOP_INSTR, err: 1'b1};
`endif
        pc_d = bus.redirect_valid ? (bus.redirect_pc & ~32'd3) : push ? pc_q + 32'd4 : pc_q;
    end

    // program counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else pc_q <= pc_d;
    end

    fetch_queue u_queue (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(bus.redirect_valid),
        .push_entry(push_entry),
        .count(count),
        .head_valid(head_valid),
        .head(head)
    );

    assign bus.rom_addr = pc_q[ROM_AW+1:2];
    assign bus.if_valid = head_valid;
    assign bus.if_instr = head.instr;
    assign bus.if_pc = head.pc;
    assign bus.if_err = head.err;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench against a queue-based fetch model
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] rom [64];
    fetch_entry_t mq [$];
    logic [31:0] mpc;
    logic [31:0] golden [3] = '{32'h24010001, 32'h00211021, 32'h00411821};

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ROM_AW(6)) bus ();

    instr_fetch_unit #(.ROM_AW(6), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.rom_instr = rom[bus.rom_addr];

    function automatic fetch_entry_t fetch_model(input logic [31:0] p);
`ifdef IFETCH_BOUNDS_EN
        if (p >= 32'd256) return '{pc: p, instr: 32'h0, err: 1'b1};
`endif
        return '{pc: p, instr: rom[(p / 4) % 64], err: 1'b0};
    endfunction

    function automatic logic [64:0] got_v();
        return bus.if_valid ? {bus.if_pc, bus.if_instr, bus.if_err} : 65'd0;
    endfunction

    function automatic logic [64:0] exp_v();
        return mq.size() != 0 ? mq[0] : 65'd0;
    endfunction

    task automatic cycle(input logic rv, input logic [31:0] rp, input logic rdy);
        logic pop, push;
        bus.redirect_valid = rv;
        bus.redirect_pc = rp;
        bus.id_ready = rdy;
        pop = mq.size() != 0 && rdy;
        push = !rv && (mq.size() < 2 || pop);
        if (pop) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
            mpc = rp & ~32'd3;
        end else if (push) begin
            mq.push_back(fetch_model(mpc));
            mpc = mpc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.id_ready = 1'b0;
        rst = 1'b1;
        mq.delete();
        mpc = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.id_ready = 1'b1;
        rst = 1'b1;
        #3;
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.if_valid); end
        checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", bus.if_instr); end
        checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.if_pc); end
        checks++; if (bus.if_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.if_err); end
        checks++; if (bus.rom_addr !== 6'd0) begin errors++; $display("FAIL reset_rom_addr got %h want 0", bus.rom_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(i * 4) || bus.if_instr !== golden[i]) begin
                errors++; $display("FAIL stream[%0d] got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, bus.if_valid, bus.if_pc, bus.if_instr, i * 4, golden[i]);
            end
            checks++; if (got_v() !== exp_v()) begin errors++; $display("FAIL stream_model[%0d] got %h want %h", i, got_v(), exp_v()); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            checks++; if (bus.rom_addr !== 6'd2 || bus.if_instr !== 32'h24010001 || bus.if_pc !== 32'h0) begin
                errors++; $display("FAIL stall[%0d] got addr=%h instr=%h pc=%h want addr=2 instr=24010001 pc=0", i, bus.rom_addr, bus.if_instr, bus.if_pc);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'((i + 1) * 4)) begin
                errors++; $display("FAIL stall_release[%0d] got v=%b pc=%h want v=1 pc=%h", i, bus.if_valid, bus.if_pc, (i + 1) * 4);
            end
            checks++; if (got_v() !== exp_v()) begin errors++; $display("FAIL stall_model[%0d] got %h want %h", i, got_v(), exp_v()); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h2E, 1'b0);
        checks++; if (bus.if_valid !== 1'b0 || bus.rom_addr !== 6'd11) begin
            errors++; $display("FAIL redirect_flush got v=%b addr=%h want v=0 addr=0b", bus.if_valid, bus.rom_addr);
        end
        cycle(1'b0, 32'h0, 1'b1);
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h2C || bus.if_instr !== 32'haea10000) begin
            errors++; $display("FAIL redirect_target got v=%b pc=%h instr=%h want v=1 pc=2c instr=aea10000", bus.if_valid, bus.if_pc, bus.if_instr);
        end
        cycle(1'b1, 32'h10, 1'b1);
        cycle(1'b1, 32'h20, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        checks++; if (bus.if_pc !== 32'h20 || got_v() !== exp_v()) begin
            errors++; $display("FAIL redirect_last_wins got pc=%h want 20 (model %h)", bus.if_pc, exp_v());
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 32'hFFFFFFFC, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        checks++; if (bus.if_pc !== 32'hFFFFFFFC || got_v() !== exp_v()) begin
            errors++; $display("FAIL wrap_top got pc=%h want fffffffc (model %h)", bus.if_pc, exp_v());
        end
        cycle(1'b0, 32'h0, 1'b1);
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h24010001) begin
            errors++; $display("FAIL wrap_zero got v=%b pc=%h instr=%h want v=1 pc=0 instr=24010001", bus.if_valid, bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_bounds();
        cycle(1'b1, 32'h100, 1'b1);
        checks++; if (bus.rom_addr !== 6'd0) begin errors++; $display("FAIL bounds_addr got %h want 0", bus.rom_addr); end
        cycle(1'b0, 32'h0, 1'b1);
`ifdef IFETCH_BOUNDS_EN
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_instr !== 32'h0 || bus.if_err !== 1'b1) begin
            errors++; $display("FAIL bounds_err got v=%b pc=%h instr=%h err=%b want v=1 pc=100 instr=0 err=1", bus.if_valid, bus.if_pc, bus.if_instr, bus.if_err);
        end
`else
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_instr !== 32'h24010001 || bus.if_err !== 1'b0) begin
            errors++; $display("FAIL bounds_alias got v=%b pc=%h instr=%h err=%b want v=1 pc=100 instr=24010001 err=0", bus.if_valid, bus.if_pc, bus.if_instr, bus.if_err);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic rv;
            logic [31:0] rp;
            rv = $urandom_range(0, 9) == 0;
            rp = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 300));
            cycle(rv, rp, 1'($urandom_range(0, 2) != 0));
            checks++; if (got_v() !== exp_v() || bus.rom_addr !== mpc[7:2]) begin
                errors++; $display("FAIL random[%0d] got %h addr=%h want %h addr=%h", i, got_v(), bus.rom_addr, exp_v(), mpc[7:2]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got v=%b want 1", bus.if_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.if_err} !== 66'd0 || bus.rom_addr !== 6'd0) begin
            errors++; $display("FAIL areset_async got v=%b instr=%h pc=%h err=%b addr=%h want all 0", bus.if_valid, bus.if_instr, bus.if_pc, bus.if_err, bus.rom_addr);
        end
        mq.delete();
        mpc = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            checks++; if (bus.if_pc !== 32'(i * 4) || got_v() !== exp_v()) begin
                errors++; $display("FAIL areset_restart[%0d] got pc=%h want %h (model %h)", i, bus.if_pc, i * 4, exp_v());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h24010001;
        rom[1] = 32'h00211021;
        rom[2] = 32'h00411821;
        rom[11] = 32'haea10000;
        mpc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_bounds();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
